// File: rtl/dm_ls_unit.sv
// Word-organised data RAM with a MIPS byte/half/word load-store alignment unit.
// Clears itself after reset (busy), then serves one request per cycle with a registered load result.
module dm_ls_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {INIT, READY} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               legal, accept, do_store, do_load, do_bad;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [3:0]         wr_be;
  logic [31:0]        wr_data;

  logic [31:0]        rd_word, rd_shift, ld_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) cnt <= cnt + IDX_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first, otherwise synthesis infers a latch.
  always_comb begin
    state_nx = state;
    if (state == INIT && cnt == IDX_W'(DEPTH - 1)) state_nx = READY;
  end

  assign busy = (state == INIT);
  assign idx  = addr[ADDR_W-1:2];
  assign lane = addr[1:0];

  always_comb begin
    case (size)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr[0];
      2'b10:   legal = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign accept   = req & ~busy;
  assign do_store = accept &  we & legal;
  assign do_load  = accept & ~we & legal;
  assign do_bad   = accept & ~legal;

  // Single write port: the clear sequence owns it while busy, stores own it afterwards.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_be   = 4'b0000;
    wr_data = '0;
    if (busy) begin
      wr_en  = 1'b1;
      wr_idx = cnt;
      wr_be  = 4'b1111;
    end else if (do_store) begin
      wr_en = 1'b1;
      case (size)
        2'b00: begin
          wr_be   = 4'b0001 << lane;
          wr_data = {4{wdata[7:0]}};
        end
        2'b01: begin
          wr_be   = addr[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = wdata;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; the post-reset clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    case (size)
      2'b00:   ld_data = {{24{sign_ext & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_data = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= do_load;
      misalign <= do_bad;
      if (do_load) rdata <= ld_data;
    end
  end

endmodule
